axi_lite_master: RTL

- AXI4-Lite initiator: converts a single-outstanding request/response command port into AXI-Lite AW/W/B and AR/R transactions.
- Counterpart of the AXI-Lite slave on the MIPS core memory/MMIO window (14-bit address space: low 8KB memory, 0x2000 = MIPS reset register).
- Used by on-chip test/loader logic to load MIPS memory and release MIPS reset.
- One transaction in flight at a time; no bursts, no reordering.

---
 rtl/axi_lite_master.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns a single-outstanding request/response command
// port into AXI-Lite AW/W/B and AR/R transactions, one at a time.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort stalled
// transactions after TIMEOUT_CYCLES with SLVERR and rsp_timeout=1.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a command, req_ready high
// WRITE   | AW and W in flight, each completes independently
// WRESP   | BREADY high, waiting for the write response
// READ    | ARVALID high until ARREADY
// RDATA   | RREADY high, waiting for read data
// RSP     | rsp_valid high, outputs frozen until rsp_ready
module axi_lite_master #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESET,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,

    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,

    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,

    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,

    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,

    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RDATA,
        S_RSP
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0]     araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic                      bready_q, bready_d;
    logic                      rready_q, rready_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic                      req_fire;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
`else
    logic                      unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Held off while reset is asserted so no command is lost at release.
    assign req_ready = (state_q == S_IDLE) & ~M_AXI_ARESET;
    assign req_fire  = req_valid & req_ready;

    // Next-state and next-output logic; all AXI outputs come from flops.
    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef AXI_MASTER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    if (req_write) begin
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_WRITE;
                    end else begin
                        araddr_d  = req_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (M_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_READ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (M_AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef AXI_MASTER_TIMEOUT_EN
        // A beat that completes on the watchdog's last cycle still wins.
        if (state_q == S_IDLE && req_fire) begin
            tmo_cnt_d     = '0;
            rsp_timeout_d = 1'b0;
        end else if (state_q == S_WRITE || state_q == S_WRESP ||
                     state_q == S_READ  || state_q == S_RDATA) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_cnt_q == TMO_LAST && state_d != S_RSP) begin
                awvalid_d     = 1'b0;
                wvalid_d      = 1'b0;
                arvalid_d     = 1'b0;
                bready_d      = 1'b0;
                rready_d      = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_resp_d    = 2'b10;
                rsp_rdata_d   = '0;
                rsp_timeout_d = 1'b1;
                state_d       = S_RSP;
            end
        end
`endif
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= S_IDLE;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    // Watchdog counter and abort flag.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
